handshake_sample_counter: RTL and testbench

//   Parametrised synchronous sequential network (RSS) that samples a W-bit input x.

---
 rtl/handshake_sample_counter.sv | 89 ++++++++
 tb/tb_handshake_sample_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/handshake_sample_counter.sv
// Samples x as {x, ^x} and hands it to a consumer over a dav_/rfd handshake,
// counting samples up to a programmable terminal value n. Optional tc flag: HSC_TC_FLAG_EN.
module handshake_sample_counter #(
  parameter int unsigned W  = 2,
  parameter int unsigned CW = 3
) (
  input  logic          clock,
  input  logic          reset_,
  input  logic [W-1:0]  x,
  input  logic [CW-1:0] n,
  input  logic          rfd,
  inout  wire           y,
  output logic [W:0]    z,
  output logic          dav_
`ifdef HSC_TC_FLAG_EN
  ,
  output logic          tc
`endif
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t        r_star;
  logic [CW-1:0] r_count;
  logic [W:0]    r_z;
  logic          r_dav_n;
  logic          r_tc;
  logic          w_x_zero;

  // Open-drain style flag: pulls low only while the input is all zeros.
  assign w_x_zero = (x == '0);
  assign y        = w_x_zero ? 1'b0 : 1'bz;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_star  <= S0;
      r_count <= '0;
      r_z     <= '0;
      r_dav_n <= 1'b1;
      r_tc    <= 1'b0;
    end else begin
      r_tc <= (r_star == S4);
      case (r_star)
        S0: begin
          r_count <= r_count + CW'(1);
          r_star  <= S1;
        end
        S1: begin
          r_z     <= {x, ^x};
          r_dav_n <= 1'b0;
          r_star  <= S2;
        end
        S2: begin
          if (!rfd) begin
            r_dav_n <= 1'b1;
            r_star  <= S3;
          end
        end
        S3: begin
          if (rfd) begin
            r_star <= (r_count == n) ? S4 : S0;
          end
        end
        S4: begin
          r_count <= '0;
          r_star  <= S0;
        end
        default: r_star <= S0;
      endcase
    end
  end

  assign z    = r_z;
  assign dav_ = r_dav_n;

`ifdef HSC_TC_FLAG_EN
  assign tc = r_tc;
`else
  logic w_unused_tc;
  assign w_unused_tc = r_tc;
`endif

endmodule

// File: tb/tb_handshake_sample_counter.sv
// Randomized consumer-side bench for handshake_sample_counter with a transaction-level
// reference model (sample counter, terminal match, handshake latencies).
module tb_handshake_sample_counter;

  localparam int unsigned W       = 2;
  localparam int unsigned CW      = 3;
  localparam int unsigned CNT_MOD = 1 << CW;

  logic          clock;
  logic          reset_;
  logic [W-1:0]  x;
  logic [CW-1:0] n;
  logic          rfd;
  wire           w_y;
  logic [W:0]    z;
  logic          dav_;
`ifdef HSC_TC_FLAG_EN
  logic          tc;
`endif

  pullup (w_y);

  handshake_sample_counter #(.W(W), .CW(CW)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .x      (x),
    .n      (n),
    .rfd    (rfd),
    .y      (w_y),
    .z      (z),
    .dav_   (dav_)
`ifdef HSC_TC_FLAG_EN
    ,
    .tc     (tc)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks;
  int n_fail;

  // Model state: samples since last clear, expected latency to next dav_ fall.
  int m_count;
  int exp_lat;
  bit exp_s4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full handshake, entered and left at a negedge just after a release point.
  task automatic do_sample(input logic [W-1:0] xv, input bit early, input int hold,
                           input int s3w, input logic [CW-1:0] nv);
    logic [W:0] exp_z;
    int         k;
    bit         got;
    bit         match;
    x = xv;
    if (early) rfd = 1'b0;
    exp_z = {xv, ^xv};
    #1 check("y", 32'(w_y), (xv == '0) ? 32'd0 : 32'd1);
    m_count = (m_count + 1) % CNT_MOD;
    k   = 0;
    got = 1'b0;
    while (k < 8 && !got) begin
      @(negedge clock);
      k++;
`ifdef HSC_TC_FLAG_EN
      check("tc", 32'(tc), 32'(exp_s4 && k == 1));
`endif
      if (dav_ == 1'b0) got = 1'b1;
    end
    check("dav_lat", 32'(k), 32'(exp_lat));
    check("z", 32'(z), 32'(exp_z));
    if (early) begin
      @(negedge clock);
      check("dav_early", 32'(dav_), 32'd1);
    end else begin
      for (int i = 0; i < hold; i++) begin
        n = CW'($urandom);
        @(negedge clock);
        check("dav_hold", 32'(dav_), 32'd0);
        check("z_hold", 32'(z), 32'(exp_z));
      end
      rfd = 1'b0;
      @(negedge clock);
      check("dav_rise", 32'(dav_), 32'd1);
    end
    for (int i = 0; i < s3w; i++) begin
      n = CW'($urandom);
      @(negedge clock);
      check("dav_s3", 32'(dav_), 32'd1);
      check("z_s3", 32'(z), 32'(exp_z));
    end
    n     = nv;
    rfd   = 1'b1;
    match = (m_count == int'(nv));
    if (match) m_count = 0;
    exp_s4  = match;
    exp_lat = match ? 3 : 2;
    @(negedge clock);
  endtask

  initial begin
    int k;
    n_checks = 0;
    n_fail   = 0;
    m_count  = 0;
    exp_lat  = 2;
    exp_s4   = 1'b0;
    reset_   = 1'b0;
    x        = 2'b01;
    n        = 3'd0;
    rfd      = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_z", 32'(z), 32'd0);
    check("rst_dav", 32'(dav_), 32'd1);
`ifdef HSC_TC_FLAG_EN
    check("rst_tc", 32'(tc), 32'd0);
`endif
    reset_ = 1'b1;

    // x=10, n=5 continuous: count cycles 1..5 then clears
    for (int i = 0; i < 12; i++)
      do_sample(2'b10, 1'b0, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 3'd5);

    // n=0: terminal only after the counter wraps
    for (int i = 0; i < 14; i++)
      do_sample(W'($urandom), 1'b0, 0, int'($urandom_range(0, 1)), 3'd0);

    do_sample(2'b00, 1'b0, 1, 1, 3'd7);
    do_sample(2'b01, 1'b0, 0, 0, 3'd7);
    do_sample(2'b11, 1'b0, 10, 2, 3'd7);
    do_sample(2'b10, 1'b1, 0, 3, 3'd7);
    do_sample(2'b01, 1'b1, 0, 0, 3'd7);

    // Reset while the sample is pending in S2
    x   = 2'b11;
    k   = 0;
    while (k < 8 && dav_ !== 1'b0) begin
      @(negedge clock);
      k++;
    end
    @(negedge clock);
    check("pre_rst_dav", 32'(dav_), 32'd0);
    #2 reset_ = 1'b0;
    #1;
    check("midrst_z", 32'(z), 32'd0);
    check("midrst_dav", 32'(dav_), 32'd1);
    check("midrst_y", 32'(w_y), 32'd1);
`ifdef HSC_TC_FLAG_EN
    check("midrst_tc", 32'(tc), 32'd0);
`endif
    @(negedge clock);
    reset_  = 1'b1;
    m_count = 0;
    exp_lat = 2;
    exp_s4  = 1'b0;

    for (int i = 0; i < 40; i++)
      do_sample(W'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), CW'($urandom_range(0, 4)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
